// File: rtl/yrv_int_pkg.sv
// yrv machine-mode interrupt controller: shared cause codes,
// irq_bus bit positions and default sizing.
package yrv_int_pkg;

    localparam int NLI_DEF    = 16;
    localparam int SYNC_DEF   = 2;
    localparam int CODE_W_DEF = 7;

    localparam logic [6:0] EC_NULL = 7'd0;
    localparam logic [6:0] EC_LI0  = 7'd16;

    localparam int IRQ_SW  = 0;
    localparam int IRQ_TMR = 1;
    localparam int IRQ_EI  = 2;
    localparam int IRQ_LI  = 3;
    localparam int IRQ_NMI = 4;
    localparam int IRQ_W   = 5;

    typedef enum logic {
        LI_LEVEL = 1'b0,
        LI_EDGE  = 1'b1
    } li_mode_e;

endpackage

// File: rtl/yrv_int_if.sv
// Signal bundle between the interrupt sources / CSR file (master)
// and the interrupt controller (slave).
interface yrv_int_if
    import yrv_int_pkg::*;
#(
    parameter int NLI    = NLI_DEF,
    parameter int CODE_W = CODE_W_DEF
);

    logic              ei_req;
    logic              sw_req;
    logic              timer_match;
    logic              nmi_req;
    logic              iack_nmi;
    logic              iack_li;
    logic [NLI-1:0]    li_req;
    logic [NLI-1:0]    li_edge;
    logic [NLI-1:0]    li_clr;

    logic              mie_reg;
    logic              wfi_state;
    logic              msie_reg;
    logic              mtie_reg;
    logic              meie_reg;
    logic [NLI-1:0]    mlie_reg;

    logic              msip_reg;
    logic              mtip_reg;
    logic              meip_reg;
    logic [NLI-1:0]    mlip_reg;
    logic [CODE_W-1:0] mli_code;
    logic              mli_valid;
    logic [IRQ_W-1:0]  irq_bus;

    modport slave (
        input  ei_req, sw_req, timer_match, nmi_req,
        input  iack_nmi, iack_li,
        input  li_req, li_edge, li_clr,
        input  mie_reg, wfi_state,
        input  msie_reg, mtie_reg, meie_reg, mlie_reg,
        output msip_reg, mtip_reg, meip_reg, mlip_reg,
        output mli_code, mli_valid, irq_bus
    );

    modport master (
        output ei_req, sw_req, timer_match, nmi_req,
        output iack_nmi, iack_li,
        output li_req, li_edge, li_clr,
        output mie_reg, wfi_state,
        output msie_reg, mtie_reg, meie_reg, mlie_reg,
        input  msip_reg, mtip_reg, meip_reg, mlip_reg,
        input  mli_code, mli_valid, irq_bus
    );

endinterface

// File: rtl/yrv_sync_edge.sv
// Multi-flop input synchroniser with a registered history bit
// for rising-edge detection.
module yrv_sync_edge
    import yrv_int_pkg::*;
#(
    parameter int STAGES = SYNC_DEF
) (
    input  logic clk,
    input  logic resetb,
    input  logic d,
    output logic level,
    output logic rise
);

    logic [STAGES-1:0] sync_q;
    logic              prev_q;

    always_ff @(posedge clk or negedge resetb) begin
        if (!resetb) begin
            sync_q <= '0;
            prev_q <= 1'b0;
        end else begin
            sync_q <= {sync_q[STAGES-2:0], d};
            prev_q <= sync_q[STAGES-1];
        end
    end

    assign level = sync_q[STAGES-1];
    assign rise  = sync_q[STAGES-1] & ~prev_q;

endmodule

// File: rtl/yrv_int_ctl.sv
// Machine-mode interrupt controller: synchronisers, pending bits,
// local-line priority encoder and the irq_bus to the trap sequencer.
module yrv_int_ctl
    import yrv_int_pkg::*;
#(
    parameter int              NLI         = NLI_DEF,
    parameter int              SYNC_STAGES = SYNC_DEF,
    parameter int              CODE_W      = CODE_W_DEF,
    parameter logic [CODE_W-1:0] LI_BASE   = CODE_W'(EC_LI0),
    parameter logic [CODE_W-1:0] NULL_CODE = CODE_W'(EC_NULL)
) (
    input  logic     clk,
    input  logic     resetb,
    yrv_int_if.slave bus
);

    if (NLI < 1 || NLI > 32) begin : g_bad_nli
        $fatal(1, "yrv_int_ctl: NLI must be 1..32");
    end

    if (SYNC_STAGES < 2) begin : g_bad_sync
        $fatal(1, "yrv_int_ctl: SYNC_STAGES must be >= 2");
    end

    if ((longint'(LI_BASE) + longint'(NLI) - 1)
        >= (longint'(1) << CODE_W)) begin : g_bad_code
        $fatal(1, "yrv_int_ctl: LI_BASE+NLI-1 exceeds CODE_W");
    end

    logic              ei_lvl;
    logic              ei_rise;
    logic              nmi_lvl;
    logic              nmi_rise;
    logic [NLI-1:0]    li_lvl;
    logic [NLI-1:0]    li_rise;
    logic              unused_sync;

    logic              msip_q;
    logic              mtip_q;
    logic              meip_q;
    logic [NLI-1:0]    mlip_q;
    logic [NLI-1:0]    mlip_nxt;
    logic [NLI-1:0]    li_ack;
    logic [NLI-1:0]    mli_pend;
    logic              nmi_seen_q;
    logic              nmi_pend_q;

    logic [CODE_W-1:0] code_q;
    logic              valid_q;
    logic [CODE_W-1:0] pri_code;
    logic              pri_hit;

    logic              int_enabl;
    logic [IRQ_W-1:0]  irq;

    yrv_sync_edge #(.STAGES(SYNC_STAGES)) u_ei (
        .clk    (clk),
        .resetb (resetb),
        .d      (bus.ei_req),
        .level  (ei_lvl),
        .rise   (ei_rise)
    );

    yrv_sync_edge #(.STAGES(SYNC_STAGES)) u_nmi (
        .clk    (clk),
        .resetb (resetb),
        .d      (bus.nmi_req),
        .level  (nmi_lvl),
        .rise   (nmi_rise)
    );

    for (genvar g = 0; g < NLI; g++) begin : g_li
        yrv_sync_edge #(.STAGES(SYNC_STAGES)) u_li (
            .clk    (clk),
            .resetb (resetb),
            .d      (bus.li_req[g]),
            .level  (li_lvl[g]),
            .rise   (li_rise[g])
        );
    end

    assign unused_sync = ei_rise ^ nmi_lvl;

    // ack only hits the line the registered cause code names
    always_comb begin
        li_ack = '0;
        for (int i = 0; i < NLI; i++) begin
            li_ack[i] = bus.iack_li & valid_q
                      & (code_q == LI_BASE + CODE_W'(i));
        end
    end

    always_comb begin
        mlip_nxt = '0;
        for (int i = 0; i < NLI; i++) begin
            unique case (li_mode_e'(bus.li_edge[i]))
                LI_EDGE: mlip_nxt[i] = li_rise[i]
                                     | (mlip_q[i]
                                        & ~bus.li_clr[i]
                                        & ~li_ack[i]);
                LI_LEVEL: mlip_nxt[i] = li_lvl[i];
                default: mlip_nxt[i] = li_lvl[i];
            endcase
        end
    end

    assign mli_pend = mlip_q & bus.mlie_reg;

    // downward scan: the last hit is the lowest index
    always_comb begin
        pri_hit  = 1'b0;
        pri_code = NULL_CODE;
        for (int i = NLI - 1; i >= 0; i--) begin
            if (mli_pend[i]) begin
                pri_hit  = 1'b1;
                pri_code = LI_BASE + CODE_W'(i);
            end
        end
    end

    always_ff @(posedge clk or negedge resetb) begin
        if (!resetb) begin
            msip_q     <= 1'b0;
            mtip_q     <= 1'b0;
            meip_q     <= 1'b0;
            mlip_q     <= '0;
            code_q     <= NULL_CODE;
            valid_q    <= 1'b0;
            nmi_seen_q <= 1'b0;
            nmi_pend_q <= 1'b0;
        end else begin
            msip_q     <= bus.sw_req;
            mtip_q     <= bus.timer_match;
            meip_q     <= ei_lvl;
            mlip_q     <= mlip_nxt;
            code_q     <= pri_code;
            valid_q    <= pri_hit;
            nmi_seen_q <= nmi_rise;
            nmi_pend_q <= nmi_seen_q
                        | (nmi_pend_q & ~bus.iack_nmi);
        end
    end

    // nmi edge is staged once more so it lands with the li request
    assign int_enabl = bus.mie_reg | bus.wfi_state;

    always_comb begin
        irq          = '0;
        irq[IRQ_SW]  = int_enabl & msip_q & bus.msie_reg;
        irq[IRQ_TMR] = int_enabl & mtip_q & bus.mtie_reg;
        irq[IRQ_EI]  = int_enabl & meip_q & bus.meie_reg;
        irq[IRQ_LI]  = int_enabl & valid_q;
        irq[IRQ_NMI] = nmi_pend_q;
    end

    assign bus.msip_reg  = msip_q;
    assign bus.mtip_reg  = mtip_q;
    assign bus.meip_reg  = meip_q;
    assign bus.mlip_reg  = mlip_q;
    assign bus.mli_code  = code_q;
    assign bus.mli_valid = valid_q;
    assign bus.irq_bus   = irq;

endmodule

// File: tb/tb_yrv_int_ctl.sv
// Bench for yrv_int_ctl: directed scenarios plus random traffic
// against a sample-history reference model.
module tb_yrv_int_ctl;
    import yrv_int_pkg::*;

    localparam int N = 16;
    localparam int S = 2;

    logic clk = 1'b0;
    logic resetb = 1'b0;
    int   n_vec = 0;
    int   n_err = 0;

    always #5 clk = ~clk;

    yrv_int_if #(.NLI(N), .CODE_W(7)) bus ();

    yrv_int_ctl #(
        .NLI         (N),
        .SYNC_STAGES (S),
        .CODE_W      (7),
        .LI_BASE     (7'd16),
        .NULL_CODE   (7'd0)
    ) dut (
        .clk    (clk),
        .resetb (resetb),
        .bus    (bus)
    );

    // model: past input samples, newest at index 0
    logic [N-1:0] h_li  [S+1];
    logic         h_ei  [S];
    logic         h_nmi [S+2];
    logic [N-1:0] m_mlip;
    logic [6:0]   m_code;
    logic         m_valid;
    logic         m_msip, m_mtip, m_meip, m_nmi;

    function automatic logic [N-1:0] f_mlip(
        input logic [N-1:0] cur, lvl, prv, edg, clr,
        input logic ack, input int ack_idx);
        logic [N-1:0] r;
        for (int i = 0; i < N; i++) begin
            if (edg[i])
                r[i] = (lvl[i] & ~prv[i])
                     | (cur[i] & ~clr[i] & ~(ack && ack_idx == i));
            else
                r[i] = lvl[i];
        end
        return r;
    endfunction

    function automatic logic [7:0] f_pri(input logic [N-1:0] p);
        for (int i = 0; i < N; i++)
            if (p[i]) return {1'b1, 7'(16 + i)};
        return 8'h00;
    endfunction

    always @(posedge clk or negedge resetb) begin
        if (!resetb) begin
            for (int k = 0; k < S + 1; k++) h_li[k] <= '0;
            for (int k = 0; k < S; k++) h_ei[k] <= 1'b0;
            for (int k = 0; k < S + 2; k++) h_nmi[k] <= 1'b0;
            m_mlip  <= '0;
            m_code  <= 7'd0;
            m_valid <= 1'b0;
            m_msip  <= 1'b0;
            m_mtip  <= 1'b0;
            m_meip  <= 1'b0;
            m_nmi   <= 1'b0;
        end else begin
            h_li[0]  <= bus.li_req;
            h_ei[0]  <= bus.ei_req;
            h_nmi[0] <= bus.nmi_req;
            for (int k = 1; k < S + 1; k++) h_li[k] <= h_li[k-1];
            for (int k = 1; k < S; k++) h_ei[k] <= h_ei[k-1];
            for (int k = 1; k < S + 2; k++) h_nmi[k] <= h_nmi[k-1];
            m_mlip <= f_mlip(m_mlip, h_li[S-1], h_li[S],
                             bus.li_edge, bus.li_clr,
                             bus.iack_li & m_valid,
                             int'(m_code) - 16);
            {m_valid, m_code} <= f_pri(m_mlip & bus.mlie_reg);
            m_msip <= bus.sw_req;
            m_mtip <= bus.timer_match;
            m_meip <= h_ei[S-1];
            m_nmi  <= (h_nmi[S] & ~h_nmi[S+1])
                    | (m_nmi & ~bus.iack_nmi);
        end
    end

    task automatic chk(input string tag,
                       input logic [31:0] got,
                       input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at %0t",
                     tag, got, exp, $time);
        end
    endtask

    task automatic cmp_all();
        logic       ie;
        logic [4:0] irq;
        ie  = bus.mie_reg | bus.wfi_state;
        irq = {m_nmi, ie & m_valid,
               ie & m_meip & bus.meie_reg,
               ie & m_mtip & bus.mtie_reg,
               ie & m_msip & bus.msie_reg};
        chk("m_mlip",  32'(bus.mlip_reg),  32'(m_mlip));
        chk("m_code",  32'(bus.mli_code),  32'(m_code));
        chk("m_valid", 32'(bus.mli_valid), 32'(m_valid));
        chk("m_msip",  32'(bus.msip_reg),  32'(m_msip));
        chk("m_mtip",  32'(bus.mtip_reg),  32'(m_mtip));
        chk("m_meip",  32'(bus.meip_reg),  32'(m_meip));
        chk("m_irq",   32'(bus.irq_bus),   32'(irq));
    endtask

    task automatic step(input int n);
        for (int k = 0; k < n; k++) begin
            @(posedge clk);
            @(negedge clk);
            cmp_all();
        end
    endtask

    initial begin
        bus.ei_req      = 1'b0;
        bus.sw_req      = 1'b0;
        bus.timer_match = 1'b0;
        bus.nmi_req     = 1'b0;
        bus.iack_nmi    = 1'b0;
        bus.iack_li     = 1'b0;
        bus.li_req      = 16'hFFFF;
        bus.li_edge     = 16'hFFFF;
        bus.li_clr      = '0;
        bus.mie_reg     = 1'b0;
        bus.wfi_state   = 1'b0;
        bus.msie_reg    = 1'b0;
        bus.mtie_reg    = 1'b0;
        bus.meie_reg    = 1'b0;
        bus.mlie_reg    = 16'hFFFF;

        repeat (2) @(negedge clk);
        cmp_all();
        chk("rst_mlip",  32'(bus.mlip_reg),  32'h0);
        chk("rst_code",  32'(bus.mli_code),  32'h0);
        chk("rst_valid", 32'(bus.mli_valid), 32'h0);
        resetb = 1'b1;

        step(2);
        chk("early_mlip", 32'(bus.mlip_reg), 32'h0);
        step(1);
        chk("rel_mlip", 32'(bus.mlip_reg), 32'hFFFF);
        step(1);
        chk("rel_code",  32'(bus.mli_code),  32'd16);
        chk("rel_valid", 32'(bus.mli_valid), 32'h1);

        bus.li_clr = 16'hFFFF;
        bus.li_req = '0;
        step(1);
        bus.li_clr = '0;
        step(4);
        chk("clr_mlip", 32'(bus.mlip_reg), 32'h0);

        bus.mlie_reg = 16'h0020;
        bus.mie_reg  = 1'b1;
        bus.li_req   = 16'h0020;
        step(1);
        bus.li_req = '0;
        step(5);
        chk("l5_mlip", 32'(bus.mlip_reg), 32'h0020);
        chk("l5_code", 32'(bus.mli_code), 32'd21);
        chk("l5_irq3", 32'(bus.irq_bus[3]), 32'h1);
        bus.iack_li = 1'b1;
        step(1);
        bus.iack_li = 1'b0;
        chk("l5_ack_mlip", 32'(bus.mlip_reg), 32'h0);
        step(1);
        chk("l5_ack_code", 32'(bus.mli_code), 32'd0);
        chk("l5_ack_irq3", 32'(bus.irq_bus[3]), 32'h0);

        bus.li_edge  = '0;
        bus.li_req   = 16'h0208;
        bus.mlie_reg = 16'h0208;
        step(4);
        chk("lv_code", 32'(bus.mli_code), 32'd19);
        bus.iack_li = 1'b1;
        step(1);
        bus.iack_li = 1'b0;
        step(1);
        chk("lv_ack_mlip", 32'(bus.mlip_reg), 32'h0208);
        chk("lv_ack_code", 32'(bus.mli_code), 32'd19);
        bus.li_req = 16'h0200;
        step(3);
        chk("lv_drop_early", 32'(bus.mli_code), 32'd19);
        step(1);
        chk("lv_drop_code", 32'(bus.mli_code), 32'd25);

        bus.li_edge = 16'h0004;
        bus.li_req  = 16'h0204;
        step(2);
        bus.li_clr = 16'h0004;
        step(1);
        bus.li_clr = '0;
        chk("setwin_l2", 32'(bus.mlip_reg[2]), 32'h1);
        step(1);
        bus.li_clr = 16'h0004;
        step(1);
        bus.li_clr = '0;
        chk("clr_l2", 32'(bus.mlip_reg[2]), 32'h0);

        bus.mie_reg = 1'b0;
        bus.li_req  = '0;
        bus.nmi_req = 1'b1;
        step(3);
        chk("nmi_early", 32'(bus.irq_bus[4]), 32'h0);
        step(1);
        chk("nmi_set", 32'(bus.irq_bus[4]), 32'h1);
        bus.iack_nmi = 1'b1;
        step(1);
        bus.iack_nmi = 1'b0;
        chk("nmi_ack", 32'(bus.irq_bus[4]), 32'h0);
        step(4);
        chk("nmi_hold", 32'(bus.irq_bus[4]), 32'h0);
        bus.nmi_req = 1'b0;

        bus.wfi_state   = 1'b1;
        bus.timer_match = 1'b1;
        bus.mtie_reg    = 1'b1;
        step(1);
        chk("wfi_irq1", 32'(bus.irq_bus[1]), 32'h1);
        bus.wfi_state = 1'b0;
        #1;
        chk("nowfi_irq1", 32'(bus.irq_bus[1]), 32'h0);
        step(1);
        chk("nowfi_mtip", 32'(bus.mtip_reg), 32'h1);
        chk("nowfi_irq1b", 32'(bus.irq_bus[1]), 32'h0);

        for (int c = 0; c < 600; c++) begin
            bus.li_req      = bus.li_req ^ 16'($urandom & $urandom);
            if ($urandom_range(0, 15) == 0)
                bus.li_edge = 16'($urandom);
            bus.li_clr      = 16'($urandom & $urandom & $urandom);
            bus.iack_li     = ($urandom_range(0, 3) == 0);
            bus.iack_nmi    = ($urandom_range(0, 7) == 0);
            bus.nmi_req     = ($urandom_range(0, 3) == 0)
                            ? ~bus.nmi_req : bus.nmi_req;
            bus.ei_req      = 1'($urandom);
            bus.sw_req      = 1'($urandom);
            bus.timer_match = 1'($urandom);
            bus.mie_reg     = 1'($urandom);
            bus.wfi_state   = ($urandom_range(0, 3) == 0);
            bus.msie_reg    = 1'($urandom);
            bus.mtie_reg    = 1'($urandom);
            bus.meie_reg    = 1'($urandom);
            if ($urandom_range(0, 7) == 0)
                bus.mlie_reg = 16'($urandom);
            step(1);
        end

        $display("== %0d vectors applied, %0d miscompares ==",
                 n_vec, n_err);
        $finish;
    end

endmodule
